// File: rtl/hash_stream_io.sv
// hash_stream_io: lane-serial front-end around an iterative Ascon-Hash core.
// Message lanes are shifted in MSB-first and digest lanes are streamed out LSB-first.
`default_nettype none

module Hash #(
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 12,
  parameter int H = 256,
  parameter int L = 256,
  parameter int Y = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startxSI,
  input  logic [Y-1:0] messagexSI,
  output logic [L-1:0] hash_textxSO,
  output logic         readyxSO
);
  localparam int NBLK = L / 64;
  localparam int BW = $clog2(NBLK + 1);
  localparam logic [3:0] RA = 4'(12 - A);
  localparam logic [3:0] RB = 4'(12 - B);
  localparam logic [63:0] IV = {8'd0, 8'(R), 8'(A), 8'(A - B), 32'(H)};
  localparam logic [2:0] C_IDLE = 3'd0, C_INIT = 3'd1, C_SQZ = 3'd2, C_DONE = 3'd3;

  if (R != 64 || Y >= R || L % 64 != 0 || L < 64 || A > 12 || B > 12 || A < 1 || B < 1) begin : g_bad_cfg
    $error("Hash: unsupported R/Y/L/A/B combination");
  end

  logic [2:0]       st_q, st_d;
  logic [4:0][63:0] x_q, x_d, x_rnd;
  logic [3:0]       rnd_q, rnd_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [L-1:0]     dig_q, dig_d;
  logic [63:0]      pad_blk;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x3 = s[3]; x4 = s[4];
    x2 = s[2] ^ {56'd0, ~i, i};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1) ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7) ^ rotr(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // Single-block absorb: message followed by a one bit, zero padded to the rate.
  assign pad_blk = 64'({messagexSI, 1'b1}) << (R - Y - 1);

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    rnd_d = rnd_q;
    blk_d = blk_q;
    dig_d = dig_q;
    x_rnd = ascon_round(x_q, rnd_q);
    case (st_q)
      C_INIT: begin
        x_d   = x_rnd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd11) begin
          x_d[0] = x_rnd[0] ^ pad_blk;
          rnd_d  = RA;
          st_d   = C_SQZ;
        end
      end
      C_SQZ: begin
        x_d   = x_rnd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd11) begin
          dig_d = (dig_q << 64) | L'(x_rnd[0]);
          blk_d = blk_q + 1'b1;
          rnd_d = RB;
          if (blk_q == BW'(NBLK - 1)) st_d = C_DONE;
        end
      end
      default: ;
    endcase
    if (startxSI) begin
      x_d    = '0;
      x_d[0] = IV;
      rnd_d  = 4'd0;
      blk_d  = '0;
      dig_d  = '0;
      st_d   = C_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= C_IDLE;
      x_q   <= '0;
      rnd_q <= '0;
      blk_q <= '0;
      dig_q <= '0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
      dig_q <= dig_d;
    end
  end

  assign hash_textxSO = dig_q;
  assign readyxSO     = (st_q == C_DONE);
endmodule

module hash_stream_io #(
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 12,
  parameter int H = 256,
  parameter int L = 256,
  parameter int Y = 32,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startxSI,
  input  logic         abortxSI,
  input  logic [W-1:0] messagexSI,
  input  logic         msg_validxSI,
  input  logic         outreadyxSI,
  output logic [W-1:0] hash_textxSO,
  output logic         hash_validxSO,
  output logic         busyxSO,
  output logic         donexSO
);
  localparam int NIN  = Y / W;
  localparam int NOUT = L / W;
  localparam int IW   = $clog2(NIN + 1);
  localparam int OW   = $clog2(NOUT + 1);
  localparam int LB   = $clog2(L);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_START = 3'd2, S_WAIT = 3'd3, S_DRAIN = 3'd4;

  if (W < 1 || W > Y || Y % W != 0 || L % W != 0) begin : g_bad_w
    $error("hash_stream_io: W must divide Y and L and be <= Y");
  end

  logic [2:0]    state_q, state_d;
  logic [Y-1:0]  msg_q, msg_d;
  logic [L-1:0]  digest_q, digest_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d, out_nxt;
  logic [W-1:0]  text_q, text_d;
  logic          valid_q, valid_d, done_q, done_d;
  logic          abort_take, core_clr, core_start, core_rst, core_ready;
  logic [L-1:0]  core_text;

  assign abort_take = abortxSI && (state_q != S_IDLE);
  assign out_nxt    = out_cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (startxSI) state_d = S_LOAD;
      S_LOAD:  if (msg_validxSI && in_cnt_q == IW'(NIN - 1)) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (core_ready) state_d = S_DRAIN;
      S_DRAIN: if (outreadyxSI && out_cnt_q == OW'(NOUT - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_take) state_d = S_IDLE;
  end

  always_comb begin
    busyxSO    = (state_q != S_IDLE);
    core_start = (state_q == S_START);
    core_clr   = ((state_q == S_IDLE) && startxSI) || abort_take;
  end

  always_comb begin
    msg_d     = msg_q;
    digest_d  = digest_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    text_d    = text_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    if (abort_take) begin
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (startxSI) begin
          msg_d     = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
        S_LOAD: if (msg_validxSI) begin
          msg_d = (msg_q << W) | Y'(messagexSI);
          if (in_cnt_q != IW'(NIN)) in_cnt_d = in_cnt_q + 1'b1;
        end
        S_WAIT: if (core_ready) begin
          digest_d = core_text;
          text_d   = core_text[W-1:0];
          valid_d  = 1'b1;
        end
        S_DRAIN: if (outreadyxSI) begin
          if (out_cnt_q != OW'(NOUT)) out_cnt_d = out_nxt;
          if (out_cnt_q == OW'(NOUT - 1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Preload the following lane so the output stays a plain register.
            text_d = digest_q[LB'(int'(out_nxt) * W) +: W];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      msg_q     <= '0;
      digest_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      text_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      digest_q  <= digest_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      text_q    <= text_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign hash_textxSO  = text_q;
  assign hash_validxSO = valid_q;
  assign donexSO       = done_q;
  assign core_rst      = ~rst | core_clr;

  Hash #(.R(R), .A(A), .B(B), .H(H), .L(L), .Y(Y)) u_core (
    .clk          (clk),
    .rst          (core_rst),
    .startxSI     (core_start),
    .messagexSI   (msg_q),
    .hash_textxSO (core_text),
    .readyxSO     (core_ready)
  );
endmodule

`default_nettype wire

// File: tb/tb_hash_stream_io.sv
// Bench for hash_stream_io: W=1 and W=8 instances checked against an Ascon-Hash reference.
`default_nettype none

module tb_hash_stream_io;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, msg_valid = 1'b0, outready = 1'b0;
  logic [7:0] lane_in = '0;
  bit         sel = 1'b0;
  logic       text1, valid1, busy1, done1;
  logic [7:0] text8;
  logic       valid8, busy8, done8;
  logic [7:0] o_lane;
  logic       valid, busy, done;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  hash_stream_io #(.W(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .startxSI(start & ~sel), .abortxSI(abort & ~sel),
    .messagexSI(lane_in[0]), .msg_validxSI(msg_valid & ~sel), .outreadyxSI(outready & ~sel),
    .hash_textxSO(text1), .hash_validxSO(valid1), .busyxSO(busy1), .donexSO(done1));

  hash_stream_io #(.W(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .startxSI(start & sel), .abortxSI(abort & sel),
    .messagexSI(lane_in), .msg_validxSI(msg_valid & sel), .outreadyxSI(outready & sel),
    .hash_textxSO(text8), .hash_validxSO(valid8), .busyxSO(busy8), .donexSO(done8));

  assign o_lane = sel ? text8 : {7'd0, text1};
  assign valid  = sel ? valid8 : valid1;
  assign busy   = sel ? busy8 : busy1;
  assign done   = sel ? done8 : done1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Twelve-round permutation, S-box applied as a 5-bit table lookup per bit column.
  function automatic logic [4:0][63:0] ref_perm(input logic [4:0][63:0] s_in);
    logic [4:0][63:0] s;
    logic [4:0] col, o;
    s = s_in;
    for (int r = 0; r < 12; r++) begin
      s[2] = s[2] ^ {56'd0, RC[r]};
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = SBOX[col];
        s[0][b] = o[4]; s[1][b] = o[3]; s[2][b] = o[2]; s[3][b] = o[1]; s[4][b] = o[0];
      end
      s[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
      s[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
      s[2] = s[2] ^ rotr(s[2], 1) ^ rotr(s[2], 6);
      s[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
      s[4] = s[4] ^ rotr(s[4], 7) ^ rotr(s[4], 41);
    end
    return s;
  endfunction

  // Digest layout: first squeezed 64-bit block in the MSBs.
  function automatic logic [255:0] ref_hash(input logic [31:0] msg);
    logic [4:0][63:0] s;
    logic [255:0] d;
    s = '0;
    s[0] = 64'h00400c0000000100;
    s = ref_perm(s);
    s[0] = s[0] ^ {msg, 32'h8000_0000};
    s = ref_perm(s);
    d = '0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) s = ref_perm(s);
      d[255 - 64 * b -: 64] = s[0];
    end
    return d;
  endfunction

  function automatic logic [7:0] exp_lane(input logic [255:0] d, input int k, input bit w8);
    return w8 ? d[8 * k +: 8] : {7'd0, d[k]};
  endfunction

  // kill: 0 none, 1 abort in WAIT, 2 abort in DRAIN, 3 async reset in DRAIN.
  task automatic run_hash(input logic [31:0] msg, input bit w8, input int gap_mode, input int rdy_mode,
                          input bit inj, input int kill, input bit skip_start, input bit b2b);
    logic [255:0] dig;
    int ni, no, k, cyc;
    bit rdy;
    sel = w8;
    ni  = w8 ? 4 : 32;
    no  = w8 ? 32 : 256;
    dig = ref_hash(msg);
    if (!skip_start) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    check_eq("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < ni; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(1, 0) == 1)) begin
        msg_valid = 1'b0; lane_in = 8'($urandom); @(negedge clk);
      end
      msg_valid = 1'b1;
      lane_in   = w8 ? msg[31 - 8 * i -: 8] : {7'd0, msg[31 - i]};
      start     = inj && (i == 1);
      @(negedge clk);
      msg_valid = 1'b0; start = 1'b0;
    end
    if (kill == 1) begin
      repeat (3) @(negedge clk);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      check_eq("abort_wait_busy", 64'(busy), 64'd0);
      for (int c = 0; c < 80; c++) begin
        check_eq("abort_wait_quiet", {62'd0, valid, done}, 64'd0);
        @(negedge clk);
      end
      return;
    end
    cyc = 0;
    while (!valid && cyc < 200) begin @(negedge clk); cyc++; end
    check_eq("valid_rise", 64'(valid), 64'd1);
    k = 0; cyc = 0;
    while (k < no && cyc < 4 * no + 16) begin
      check_eq("lane", 64'(o_lane), 64'(exp_lane(dig, k, w8)));
      check_eq("valid_hold", 64'(valid), 64'd1);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      if (kill == 2 && k == 3) begin
        abort = 1'b1; outready = 1'b1; @(negedge clk); abort = 1'b0; outready = 1'b0;
        check_eq("abort_drain", {61'd0, valid, busy, done}, 64'd0);
        @(negedge clk);
        check_eq("abort_drain_nodone", {62'd0, valid, done}, 64'd0);
        return;
      end
      if (kill == 3 && k == 3) begin
        #2 rst = 1'b0;
        #1 check_eq("async_reset", {53'd0, o_lane, valid, busy, done}, 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_eq("post_reset_quiet", {62'd0, valid, busy}, 64'd0);
        end
        return;
      end
      outready = rdy;
      start    = inj && (k == 2);
      @(negedge clk);
      outready = 1'b0; start = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    check_eq("drain_count", 64'(k), 64'(no));
    check_eq("done_end", {61'd0, done, busy, valid}, 64'b100);
    if (b2b) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
    end else begin
      @(negedge clk);
      check_eq("done_once", 64'(done), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("reset_w1", {60'd0, text1, valid1, busy1, done1}, 64'd0);
    check_eq("reset_w8", {53'd0, text8, valid8, busy8, done8}, 64'd0);
    @(negedge clk); rst = 1'b1;

    run_hash(32'h0000_0000, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    run_hash(32'hDEAD_BEEF, 1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    run_hash($urandom, 1'b1, 0, 1, 1'b0, 0, 1'b0, 1'b0);
    run_hash(32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0, 1, 1'b0, 1'b0);
    run_hash(32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    run_hash($urandom, 1'b1, 2, 2, 1'b1, 0, 1'b0, 1'b0);
    run_hash($urandom, 1'b1, 2, 2, 1'b0, 2, 1'b0, 1'b0);
    run_hash($urandom, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    run_hash($urandom, 1'b1, 2, 1, 1'b0, 0, 1'b1, 1'b0);
    run_hash($urandom, 1'b0, 0, 0, 1'b0, 3, 1'b0, 1'b0);
    run_hash($urandom, 1'b0, 2, 2, 1'b0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++)
      run_hash($urandom, 1'b1, $urandom_range(2, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)), 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
